// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a per-register pending-write scoreboard that stalls decode on RAW hazards.
// Optional write-through bypass and early stall release: define REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CNTW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          weW,
    input  logic [AW-1:0] writeregW,
    input  logic [DW-1:0] resultW,
    input  logic [AW-1:0] ra1D,
    input  logic [AW-1:0] ra2D,
    input  logic          use1D,
    input  logic          use2D,
    output logic [DW-1:0] rd1D,
    output logic [DW-1:0] rd2D,
    input  logic          issueD,
    input  logic          regwriteD,
    input  logic [AW-1:0] writeregD,
    output logic          stallD,
    output logic [1:0]    sbErr
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [DW-1:0]   regs     [NREG];
    logic [CNTW-1:0] cnt      [NREG];
    logic [CNTW-1:0] cnt_next [NREG];
    logic            issue_eff;
    logic            ret_eff;
    logic            pend1;
    logic            pend2;
    logic            ovf;
    logic            unf;

    // Writes to r0 never retire and never issue, so r0 is never tracked.
    assign ret_eff   = weW & (writeregW != '0);
    assign issue_eff = issueD & ~stallD & regwriteD & (writeregD != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pend1 = use1D & (ra1D != '0) & (cnt[ra1D] != '0);
        pend2 = use2D & (ra2D != '0) & (cnt[ra2D] != '0);
`ifdef REGFILE_BYPASS_EN
        // The last outstanding write retiring now satisfies the read through the bypass.
        if (ret_eff && (writeregW == ra1D) && (cnt[ra1D] == CNT_ONE)) pend1 = 1'b0;
        if (ret_eff && (writeregW == ra2D) && (cnt[ra2D] == CNT_ONE)) pend2 = 1'b0;
`endif
        stallD = pend1 | pend2;
    end

    always_comb begin
        rd1D = (ra1D == '0) ? '0 : regs[ra1D];
        rd2D = (ra2D == '0) ? '0 : regs[ra2D];
`ifdef REGFILE_BYPASS_EN
        if (weW && (writeregW == ra1D) && (ra1D != '0)) rd1D = resultW;
        if (weW && (writeregW == ra2D) && (ra2D != '0)) rd2D = resultW;
`endif
    end

    // Issue and retire to the same register cancel; saturating ends raise the sticky flags.
    always_comb begin
        ovf = 1'b0;
        unf = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            case ({issue_eff && (writeregD == AW'(r)), ret_eff && (writeregW == AW'(r))})
                2'b10: begin
                    if (cnt[r] == CNT_MAX) ovf = 1'b1;
                    else                   cnt_next[r] = cnt[r] + CNT_ONE;
                end
                2'b01: begin
                    if (cnt[r] == '0) unf = 1'b1;
                    else              cnt_next[r] = cnt[r] - CNT_ONE;
                end
                default: cnt_next[r] = cnt[r];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: the register file is cleared on reset because its architectural state must read 0 afterwards.
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sbErr <= '0;
        end else begin
            if (ret_eff) regs[writeregW] <= resultW;
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
            sbErr <= sbErr | {unf, ovf};
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed hazard scenarios then random traffic vs. a behavioural model.
// Build with REGFILE_BYPASS_EN defined to check the bypass variant.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CNTW = 2;
    localparam int MAXC = (1 << CNTW) - 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr, weW, use1D, use2D, issueD, regwriteD;
    logic [AW-1:0] writeregW, ra1D, ra2D, writeregD;
    logic [DW-1:0] resultW, rd1D, rd2D;
    logic          stallD;
    logic [1:0]    sbErr;

    regfile_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .clr(clr), .weW(weW), .writeregW(writeregW), .resultW(resultW),
        .ra1D(ra1D), .ra2D(ra2D), .use1D(use1D), .use2D(use2D),
        .rd1D(rd1D), .rd2D(rd2D), .issueD(issueD), .regwriteD(regwriteD),
        .writeregD(writeregD), .stallD(stallD), .sbErr(sbErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          stall;
        logic [1:0]    err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   finish_req = 1'b0;

    // Reference model: architectural values, in-flight write counts, sticky flags.
    logic [DW-1:0] reg_m [NREG];
    int            cnt_m [NREG];
    logic [1:0]    err_m;

    function automatic logic model_pend(input logic use_, input logic [AW-1:0] ra);
        if (!use_ || ra == 0 || cnt_m[ra] == 0) return 1'b0;
        if (BYPASS && cnt_m[ra] == 1 && weW && writeregW == ra) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
        if (BYPASS && weW && writeregW == ra) return resultW;
        return reg_m[ra];
    endfunction

    task automatic model_update(input logic stall);
        bit iss, ret;
        if (clr) begin
            for (int r = 0; r < NREG; r++) begin
                reg_m[r] = '0;
                cnt_m[r] = 0;
            end
            err_m = 2'b00;
            return;
        end
        iss = issueD && !stall && regwriteD && writeregD != 0;
        ret = weW && writeregW != 0;
        if (ret) reg_m[writeregW] = resultW;
        if (iss && ret && writeregD == writeregW) return;
        if (iss) begin
            if (cnt_m[writeregD] == MAXC) err_m[0] = 1'b1;
            else cnt_m[writeregD]++;
        end
        if (ret) begin
            if (cnt_m[writeregW] == 0) err_m[1] = 1'b1;
            else cnt_m[writeregW]--;
        end
    endtask

    // One clock: push this cycle's expectation, then advance the model at the edge.
    task automatic cycle(input bit do_check);
        exp_t e;
        logic st;
        st = model_pend(use1D, ra1D) | model_pend(use2D, ra2D);
        if (do_check) begin
            e.rd1   = model_rd(ra1D);
            e.rd2   = model_rd(ra2D);
            e.stall = st;
            e.err   = err_m;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_update(st);
        #1;
    endtask

    task automatic idle();
        clr = 0; weW = 0; writeregW = '0; resultW = '0;
        ra1D = '0; ra2D = '0; use1D = 0; use2D = 0;
        issueD = 0; regwriteD = 0; writeregD = '0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rd1D",   rd1D,           mon_e.rd1);
            check("rd2D",   rd2D,           mon_e.rd2);
            check("stallD", {31'b0, stallD}, {31'b0, mon_e.stall});
            check("sbErr",  {30'b0, sbErr},  {30'b0, mon_e.err});
        end else if (finish_req) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 3));
    endfunction

    initial begin
        err_m = 2'b00;
        for (int r = 0; r < NREG; r++) begin
            reg_m[r] = '0;
            cnt_m[r] = 0;
        end

        // Reset, then read r5 and r0.
        idle(); clr = 1; cycle(0);
        idle(); ra1D = 5; use1D = 1; use2D = 1; cycle(1);

        // Issue to r8, retire three cycles later while a reader waits.
        idle(); issueD = 1; regwriteD = 1; writeregD = 8; cycle(1);
        idle(); issueD = 1; use1D = 1; ra1D = 8; cycle(1); cycle(1);
        weW = 1; writeregW = 8; resultW = 32'h1234_5678; cycle(1);
        weW = 0; cycle(1); cycle(1);

        // Register 0 writes and issues are ignored.
        idle(); issueD = 1; regwriteD = 1; writeregD = 0;
        weW = 1; writeregW = 0; resultW = 32'hFFFF_FFFF; use1D = 1; cycle(1);
        idle(); use1D = 1; use2D = 1; cycle(1);

        // Same-cycle issue and retire on r3 keep the count at one.
        idle(); issueD = 1; regwriteD = 1; writeregD = 3; cycle(1);
        weW = 1; writeregW = 3; resultW = $urandom; cycle(1);
        idle(); use1D = 1; ra1D = 3; cycle(1);
        weW = 1; writeregW = 3; resultW = $urandom; cycle(1);
        weW = 0; cycle(1);

        // Overflow then underflow on r9; flags persist.
        idle(); issueD = 1; regwriteD = 1; writeregD = 9; repeat (4) cycle(1);
        idle(); weW = 1; writeregW = 9; ra1D = 9;
        repeat (4) begin resultW = $urandom; cycle(1); end
        idle(); ra1D = 9; use1D = 1; repeat (3) cycle(1);

        // A stalled issue must not count.
        idle(); issueD = 1; regwriteD = 1; writeregD = 10; cycle(1);
        use1D = 1; ra1D = 10; cycle(1); cycle(1);
        idle(); weW = 1; writeregW = 10; resultW = $urandom; use2D = 1; ra2D = 10; cycle(1);
        idle(); use2D = 1; ra2D = 10; cycle(1);

        // Reset in the middle of a dependency.
        idle(); issueD = 1; regwriteD = 1; writeregD = 12; cycle(1);
        idle(); use1D = 1; ra1D = 12; clr = 1; cycle(1);
        clr = 0; cycle(1);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            clr       = ($urandom_range(0, 39) == 0);
            weW       = ($urandom_range(0, 2) == 0);
            writeregW = rand_reg();
            resultW   = $urandom;
            ra1D      = rand_reg();
            ra2D      = rand_reg();
            use1D     = $urandom_range(0, 1);
            use2D     = $urandom_range(0, 1);
            issueD    = $urandom_range(0, 1);
            regwriteD = $urandom_range(0, 1);
            writeregD = rand_reg();
            cycle(1);
        end

        idle(); cycle(1);
        finish_req = 1'b1;
    end

endmodule
